// File: rtl/flow_bus_deserializer.sv
// Packs DATA_NUM narrow flow-bus beats into one wide word; slice 0 holds the first beat.
// One-cycle latency from the last beat; one output holding register with pass-through ready.
module flow_bus_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_NUM   = 2,
  parameter int USE_ENABLE = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           sync,
  output logic                           up_ready,
  input  logic                           up_valid,
  input  logic [DATA_WIDTH-1:0]          up_data,
  input  logic                           down_ready,
  output logic                           down_valid,
  output logic [DATA_WIDTH*DATA_NUM-1:0] down_data,
  output logic                           partial
);

  localparam int OUT_W = DATA_WIDTH * DATA_NUM;
  localparam int ASM_W = (DATA_NUM > 1) ? (DATA_NUM - 1) * DATA_WIDTH : 1;
  localparam logic [DATA_NUM-1:0] SLOT_FIRST = (DATA_NUM)'(1);

  logic                en_i;
  logic                up_fire;
  logic                down_fire;
  logic [DATA_NUM-1:0] slot_q, slot_d;
  logic [DATA_NUM-1:0] eff_slot;
  logic [ASM_W-1:0]    asm_q, asm_d;
  logic                out_valid_q, out_valid_d;
  logic [OUT_W-1:0]    out_data_q, out_data_d;
  logic [OUT_W-1:0]    full_word;

  assign en_i = (USE_ENABLE != 0) ? enable : 1'b1;

  // Ready only depends on down_ready when the incoming beat would complete a word.
  assign up_ready   = en_i & (~slot_q[DATA_NUM-1] | ~out_valid_q | down_ready);
  assign up_fire    = up_valid & up_ready;
  assign down_valid = out_valid_q & en_i;
  assign down_data  = out_data_q;
  assign down_fire  = down_valid & down_ready;
  assign partial    = ~slot_q[0];

  // A realign redirects a coincident beat into slice 0.
  assign eff_slot = sync ? SLOT_FIRST : slot_q;

  generate
    if (DATA_NUM > 1) begin : g_multi
      assign full_word = {up_data, asm_q};
    end else begin : g_single
      assign full_word = up_data;
    end
  endgenerate

  always_comb begin
    slot_d      = slot_q;
    asm_d       = asm_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (en_i) begin
      if (sync) begin
        slot_d = SLOT_FIRST;
      end
      if (down_fire) begin
        out_valid_d = 1'b0;
      end
      if (up_fire) begin
        if (eff_slot[DATA_NUM-1]) begin
          out_data_d  = full_word;
          out_valid_d = 1'b1;
          slot_d      = SLOT_FIRST;
        end else begin
          for (int k = 0; k < DATA_NUM - 1; k++) begin
            if (eff_slot[k]) begin
              asm_d[k*DATA_WIDTH +: DATA_WIDTH] = up_data;
            end
          end
          slot_d = eff_slot << 1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q      <= SLOT_FIRST;
      asm_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      slot_q      <= slot_d;
      asm_q       <= asm_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule
